// File: rtl/int_vector_unit.sv
// Interrupt latch, mask/priority select, per-source vectors and return-PC stack.
// Define INT_NEST_EN to allow strictly-higher-priority preemption up to DEPTH levels.
module int_vector_unit #(
  parameter int              N_SRC      = 4,
  parameter int              PC_W       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [31:0]     VEC_BASE   = 32'h10,
  parameter logic [31:0]     VEC_STRIDE = 32'h8,
  parameter logic [N_SRC-1:0] MASK_RST  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             int_take,
  input  logic             int_ret,
  input  logic             err_clr,
  output logic             int_req,
  output logic [PC_W-1:0]  int_vector,
  output logic [PC_W-1:0]  restore_pc,
  output logic [3:0]       active_id,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             err
);

`ifdef INT_NEST_EN
  localparam int ED = DEPTH;
`else
  localparam int ED = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] clr;
  logic [CW-1:0]    cnt;
  logic [3:0]       id_stk [DEPTH];
  logic [PC_W-1:0]  pc_stk [DEPTH];
  logic [3:0]       req_id;
  logic [3:0]       cand;
  logic [AW-1:0]    top;
  logic [AW-1:0]    wr;
  logic             hit;
  logic             elig;
  logic             take_ok;
  logic             pop;
  logic             push;
  logic             err_new;

  function automatic logic [PC_W-1:0] vec_of(input logic [3:0] id);
    return PC_W'(VEC_BASE) + PC_W'(id) * PC_W'(VEC_STRIDE);
  endfunction

  assign edges       = irq & ~irq_prev;
  assign top         = AW'(cnt - CW'(1));
  assign stack_empty = (cnt == '0);
  assign stack_full  = (cnt == CW'(ED));
  assign restore_pc  = stack_empty ? '0 : pc_stk[top];
  assign active_id   = stack_empty ? '0 : id_stk[top];

  // Scan downward so the lowest enabled index is the final winner
  always_comb begin
    hit  = 1'b0;
    cand = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i] && mask[i]) begin
        hit  = 1'b1;
        cand = 4'(i);
      end
    end
  end

`ifdef INT_NEST_EN
  assign elig = hit && !stack_full &&
                (stack_empty || (cand < active_id));
`else
  assign elig = hit && stack_empty;
`endif

  assign take_ok = int_take & int_req;
  assign pop     = int_ret & ~stack_empty;
  assign push    = take_ok & (~stack_full | pop);
  assign err_new = (int_take & ~int_req)
                 | (int_ret & stack_empty)
                 | (take_ok & ~push);
  assign clr     = push ? (N_SRC'(1) << req_id) : '0;
  // Simultaneous pop+push overwrites the current top in place
  assign wr      = pop ? top : AW'(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      irq_prev   <= '0;
      mask       <= MASK_RST;
      cnt        <= '0;
      int_req    <= 1'b0;
      int_vector <= '0;
      req_id     <= '0;
      err        <= 1'b0;
    end else begin
      pending  <= (pending & ~clr) | edges;
      irq_prev <= irq;
      if (mask_we)
        mask <= mask_wdata;
      if (push && !pop)
        cnt <= cnt + CW'(1);
      else if (pop && !push)
        cnt <= cnt - CW'(1);
      int_req    <= elig && !take_ok;
      int_vector <= (elig && !take_ok) ? vec_of(cand) : '0;
      req_id     <= cand;
      err        <= (err & ~err_clr) | err_new;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_stk[wr] <= req_id;
      pc_stk[wr] <= pc_in;
    end
  end

endmodule

// File: tb/tb_int_vector_unit.sv
// Directed and random checks of int_vector_unit against a queue-based model.
// Follows INT_NEST_EN the same way the design does.
module tb_int_vector_unit;

`ifdef INT_NEST_EN
  localparam bit NEST = 1'b1;
  localparam int ED   = 4;
`else
  localparam bit NEST = 1'b0;
  localparam int ED   = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [31:0] pc_in;
  logic        int_take;
  logic        int_ret;
  logic        err_clr;
  logic        int_req;
  logic [31:0] int_vector;
  logic [31:0] restore_pc;
  logic [3:0]  active_id;
  logic        stack_empty;
  logic        stack_full;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [3:0]  m_pend;
  logic [3:0]  m_prev;
  logic [3:0]  m_mask;
  logic        m_req;
  logic [31:0] m_vec;
  logic [3:0]  m_rid;
  logic        m_err;
  logic [35:0] stk[$];

  int_vector_unit #(
    .N_SRC(4), .PC_W(32), .DEPTH(4),
    .VEC_BASE(32'h10), .VEC_STRIDE(32'h8),
    .MASK_RST(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pc_in(pc_in), .int_take(int_take),
    .int_ret(int_ret), .err_clr(err_clr),
    .int_req(int_req), .int_vector(int_vector),
    .restore_pc(restore_pc), .active_id(active_id),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_mask = 4'hF;
    m_req = 1'b0; m_vec = '0; m_rid = '0; m_err = 1'b0;
    stk.delete();
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_req"}, 32'(int_req), 0);
    chk({p, "_vec"}, int_vector, 0);
    chk({p, "_rpc"}, restore_pc, 0);
    chk({p, "_aid"}, 32'(active_id), 0);
    chk({p, "_empty"}, 32'(stack_empty), 1);
    chk({p, "_full"}, 32'(stack_full), 0);
    chk({p, "_err"}, 32'(err), 0);
  endtask

  task automatic chk_model();
    logic [35:0] t;
    t = (stk.size() > 0) ? stk[$] : 36'h0;
    chk("m_req", 32'(int_req), 32'(m_req));
    chk("m_vec", int_vector, m_vec);
    chk("m_rpc", restore_pc, t[31:0]);
    chk("m_aid", 32'(active_id), 32'(t[35:32]));
    chk("m_empty", 32'(stack_empty), 32'(stk.size() == 0));
    chk("m_full", 32'(stack_full), 32'(stk.size() == ED));
    chk("m_err", 32'(err), 32'(m_err));
  endtask

  // One clock: model advances from the inputs held across the edge
  task automatic tick();
    logic [3:0] e, np, c, aid, s_irq, s_wd;
    logic [31:0] s_pc;
    bit tok, pp, ps, en, h, el, s_mwe, s_clr;
    int sz;
    s_irq = irq; s_wd = mask_wdata; s_mwe = mask_we;
    s_pc = pc_in; s_clr = err_clr;
    sz  = stk.size();
    aid = (sz > 0) ? stk[$][35:32] : 4'd0;
    e   = s_irq & ~m_prev;
    tok = int_take && m_req;
    pp  = int_ret && sz > 0;
    ps  = tok && (sz < ED || pp);
    en  = (int_take && !m_req) || (int_ret && sz == 0) || (tok && !ps);
    h = 0; c = 0;
    for (int i = 0; i < 4; i++)
      if (!h && m_pend[i] && m_mask[i]) begin h = 1; c = 4'(i); end
    el = h && sz < ED && (sz == 0 || (NEST && c < aid));
    np = m_pend;
    if (ps && !e[m_rid]) np[m_rid] = 1'b0;
    np = np | e;
    @(posedge clk);
    if (pp) void'(stk.pop_back());
    if (ps) stk.push_back({m_rid, s_pc});
    m_req  = el && !tok;
    m_vec  = m_req ? 32'h10 + 32'(c) * 8 : 32'h0;
    m_rid  = c;
    m_err  = (m_err && !s_clr) || en;
    if (s_mwe) m_mask = s_wd;
    m_prev = s_irq;
    m_pend = np;
    #1;
    chk_model();
  endtask

  task automatic serve();
    int_take = 1; tick(); int_take = 0;
    int_ret = 1; tick(); int_ret = 0;
  endtask

  initial begin
    rst_n = 0; irq = 0; mask_we = 0; mask_wdata = 0;
    pc_in = 0; int_take = 0; int_ret = 0; err_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk_reset_vals("rst");

    // 1: single source, take and return
    irq = 4'b0100; tick(); tick();
    chk("t1_req", 32'(int_req), 1);
    chk("t1_vec", int_vector, 32'h20);
    irq = 0; pc_in = 32'h40; int_take = 1; tick(); int_take = 0;
    chk("t1_empty", 32'(stack_empty), 0);
    chk("t1_aid", 32'(active_id), 2);
    int_ret = 1;
    chk("t1_rpc", restore_pc, 32'h40);
    tick(); int_ret = 0;
    chk("t1_empty2", 32'(stack_empty), 1);

    // 2: simultaneous sources, priority order
    irq = 4'b1010; tick(); tick(); irq = 0;
    chk("t2_vec1", int_vector, 32'h18);
    pc_in = 32'h50; serve(); tick();
    chk("t2_req2", 32'(int_req), 1);
    chk("t2_vec2", int_vector, 32'h28);
    serve();

`ifdef INT_NEST_EN
    // 3: preemption by higher priority only
    irq = 4'b1000; tick(); tick();
    pc_in = 32'h300; irq = 0; int_take = 1; tick(); int_take = 0;
    irq = 4'b0001; tick(); tick();
    chk("t3_vec", int_vector, 32'h10);
    pc_in = 32'h100; irq = 0; int_take = 1; tick(); int_take = 0;
    chk("t3_aid", 32'(active_id), 0);
    irq = 4'b1000; tick(); irq = 0; tick(); tick();
    chk("t3_noreq", 32'(int_req), 0);
    int_ret = 1;
    chk("t3_rpc1", restore_pc, 32'h100);
    tick();
    chk("t3_rpc2", restore_pc, 32'h300);
    tick(); int_ret = 0; tick();
    chk("t3_req", 32'(int_req), 1);
    chk("t3_vec3", int_vector, 32'h28);
    serve();
`endif

    // 4: masked source requests once unmasked
    mask_we = 1; mask_wdata = 0; tick(); mask_we = 0;
    irq = 4'b0001; tick(); tick(); tick(); irq = 0;
    chk("t4_masked", 32'(int_req), 0);
    mask_we = 1; mask_wdata = 4'hF; tick(); mask_we = 0; tick();
    chk("t4_req", 32'(int_req), 1);
    chk("t4_vec", int_vector, 32'h10);
    serve();

    // 5: protocol errors and clear
    int_ret = 1; tick(); int_ret = 0;
    chk("t5_err1", 32'(err), 1);
    int_take = 1; tick(); int_take = 0;
    chk("t5_err2", 32'(err), 1);
    chk("t5_empty", 32'(stack_empty), 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("t5_clr", 32'(err), 0);

    // 6: async reset in service
    irq = 4'b1000; tick(); tick();
    pc_in = 32'h300; irq = 0; int_take = 1; tick(); int_take = 0;
`ifdef INT_NEST_EN
    irq = 4'b0001; tick(); tick();
    pc_in = 32'h100; irq = 0; int_take = 1; tick(); int_take = 0;
`endif
    chk("t6_busy", 32'(stack_empty), 0);
    #2 rst_n = 0;
    #1 chk_reset_vals("t6");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      irq = 4'($urandom) & 4'($urandom) & 4'($urandom);
      pc_in = $urandom;
      int_take = m_req ? ($urandom_range(0, 1) == 1)
                       : ($urandom_range(0, 19) == 0);
      int_ret = (stk.size() > 0) ? ($urandom_range(0, 3) == 0)
                                 : ($urandom_range(0, 29) == 0);
      mask_we = ($urandom_range(0, 14) == 0);
      mask_wdata = 4'($urandom);
      err_clr = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
